// File: rtl/csr_file.sv
// CSR file for the execute stage: scratch bank, 64-bit cycle/instret counters,
// and a valid/ready bridge that forwards unmapped CSRs to an external bus.
module csr_file #(
  parameter logic [11:0] SCRATCH_BASE  = 12'h7C0,
  parameter int          SCRATCH_COUNT = 4,
  parameter int          COUNTERS_EN   = 1,
  parameter int          EXT_TIMEOUT   = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_retire,
  output logic [31:0] o_rd_data,
  output logic        o_busy,
  output logic        o_illegal,
  output logic [11:0] o_ext_addr,
  output logic [31:0] o_ext_wr_data,
  output logic        o_ext_wr,
  output logic        o_ext_rd,
  output logic        o_ext_valid,
  input  logic        i_ext_ready,
  input  logic [31:0] i_ext_rd_data
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WR_REQ = 2'd2, ST_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3} op_t;

  localparam logic [11:0] SCR_COUNT = 12'(SCRATCH_COUNT);
  localparam logic [7:0]  TMO_LAST  = 8'(EXT_TIMEOUT - 1);
  localparam logic        CNT_EN    = (COUNTERS_EN != 0);

  state_t      state_r;
  op_t         op_r;
  op_t         op_s;
  logic [7:0]  timer_r;
  logic        timeout_r;
  logic [31:0] rdata_r;
  logic [31:0] wmask_r;
  logic [11:0] ext_addr_r;
  logic [31:0] ext_wdata_r;
  logic        ext_wr_r;
  logic        ext_rd_r;
  logic        ext_valid_r;
  logic [31:0] scratch_r [SCRATCH_COUNT];
  logic [63:0] cycle_r;
  logic [63:0] instret_r;

  logic        access_s, wr_eff_s, ro_space_s, idle_s;
  logic [11:0] scr_off_s;
  logic        scr_hit_s, cyc_lo_s, cyc_hi_s, ins_lo_s, ins_hi_s, int_hit_s;
  logic [31:0] old_s, new_s;
  logic        illegal_s, int_we_s, ext_go_s;

  // Request decode, internal read mux and next-value computation
  always_comb begin
    access_s   = i_rd | i_wr | i_set | i_clr;
    wr_eff_s   = i_wr | ((i_set | i_clr) & (i_wr_data != 32'd0));
    ro_space_s = (i_addr[11:10] == 2'b11);
    scr_off_s  = i_addr - SCRATCH_BASE;
    scr_hit_s  = (scr_off_s < SCR_COUNT);
    cyc_lo_s   = 1'b0;
    cyc_hi_s   = 1'b0;
    ins_lo_s   = 1'b0;
    ins_hi_s   = 1'b0;
    if (CNT_EN && !scr_hit_s) begin
      cyc_lo_s = (i_addr == 12'hB00) || (i_addr == 12'hC00);
      cyc_hi_s = (i_addr == 12'hB80) || (i_addr == 12'hC80);
      ins_lo_s = (i_addr == 12'hB02) || (i_addr == 12'hC02);
      ins_hi_s = (i_addr == 12'hB82) || (i_addr == 12'hC82);
    end else begin
      cyc_lo_s = 1'b0;
      cyc_hi_s = 1'b0;
      ins_lo_s = 1'b0;
      ins_hi_s = 1'b0;
    end
    int_hit_s = scr_hit_s | cyc_lo_s | cyc_hi_s | ins_lo_s | ins_hi_s;

    old_s = 32'd0;
    if (scr_hit_s) begin
      for (int n = 0; n < SCRATCH_COUNT; n++) begin
        old_s = (scr_off_s == 12'(n)) ? scratch_r[n] : old_s;
      end
    end else if (cyc_lo_s) begin
      old_s = cycle_r[31:0];
    end else if (cyc_hi_s) begin
      old_s = cycle_r[63:32];
    end else if (ins_lo_s) begin
      old_s = instret_r[31:0];
    end else if (ins_hi_s) begin
      old_s = instret_r[63:32];
    end else begin
      old_s = 32'd0;
    end

    if (i_wr) begin
      new_s = i_wr_data;
      op_s  = OP_WR;
    end else if (i_set) begin
      new_s = old_s | i_wr_data;
      op_s  = OP_SET;
    end else if (i_clr) begin
      new_s = old_s & ~i_wr_data;
      op_s  = OP_CLR;
    end else begin
      new_s = old_s;
      op_s  = OP_RD;
    end

    // Only the idle state accepts new work; held inputs are ignored while a bus access runs
    idle_s    = (state_r == ST_IDLE) && !i_rst;
    illegal_s = idle_s & access_s & wr_eff_s & ro_space_s;
    int_we_s  = idle_s & access_s & wr_eff_s & !ro_space_s & int_hit_s;
    ext_go_s  = idle_s & access_s & !int_hit_s & !(wr_eff_s & ro_space_s);
  end

  assign o_busy        = ext_go_s | (state_r == ST_REQ) | (state_r == ST_WR_REQ);
  assign o_illegal     = illegal_s | ((state_r == ST_DONE) & timeout_r);
  assign o_rd_data     = (state_r == ST_DONE) ? rdata_r : (idle_s ? old_s : 32'd0);
  assign o_ext_addr    = ext_addr_r;
  assign o_ext_wr_data = ext_wdata_r;
  assign o_ext_wr      = ext_wr_r;
  assign o_ext_rd      = ext_rd_r;
  assign o_ext_valid   = ext_valid_r;

  // Scratch bank writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < SCRATCH_COUNT; n++) scratch_r[n] <= 32'd0;
    end else begin
      for (int n = 0; n < SCRATCH_COUNT; n++) begin
        if (int_we_s && scr_hit_s && (scr_off_s == 12'(n))) scratch_r[n] <= new_s;
      end
    end
  end

  // Counters: a write to either half replaces it and holds the whole counter that cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
    end else begin
      if (int_we_s && cyc_lo_s)      cycle_r[31:0]  <= new_s;
      else if (int_we_s && cyc_hi_s) cycle_r[63:32] <= new_s;
      else                           cycle_r        <= cycle_r + 64'd1;
      if (int_we_s && ins_lo_s)      instret_r[31:0]  <= new_s;
      else if (int_we_s && ins_hi_s) instret_r[63:32] <= new_s;
      else if (i_retire)             instret_r        <= instret_r + 64'd1;
    end
  end

  // External bus sequencer with per-phase timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_RD;
      timer_r     <= 8'd0;
      timeout_r   <= 1'b0;
      rdata_r     <= 32'd0;
      wmask_r     <= 32'd0;
      ext_addr_r  <= 12'd0;
      ext_wdata_r <= 32'd0;
      ext_wr_r    <= 1'b0;
      ext_rd_r    <= 1'b0;
      ext_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ext_go_s) begin
            op_r        <= op_s;
            wmask_r     <= i_wr_data;
            ext_addr_r  <= i_addr;
            ext_wdata_r <= i_wr ? i_wr_data : 32'd0;
            ext_wr_r    <= i_wr;
            ext_rd_r    <= !i_wr;
            ext_valid_r <= 1'b1;
            timer_r     <= 8'd0;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ext_ready) begin
            rdata_r <= i_ext_rd_data;
            if (((op_r == OP_SET) || (op_r == OP_CLR)) && (wmask_r != 32'd0)) begin
              ext_wdata_r <= (op_r == OP_SET) ? (i_ext_rd_data | wmask_r)
                                              : (i_ext_rd_data & ~wmask_r);
              ext_wr_r    <= 1'b1;
              ext_rd_r    <= 1'b0;
              timer_r     <= 8'd0;
              state_r     <= ST_WR_REQ;
            end else begin
              ext_addr_r  <= 12'd0;
              ext_wdata_r <= 32'd0;
              ext_wr_r    <= 1'b0;
              ext_rd_r    <= 1'b0;
              ext_valid_r <= 1'b0;
              state_r     <= ST_DONE;
            end
          end else if (timer_r == TMO_LAST) begin
            rdata_r     <= 32'd0;
            timeout_r   <= 1'b1;
            ext_addr_r  <= 12'd0;
            ext_wdata_r <= 32'd0;
            ext_wr_r    <= 1'b0;
            ext_rd_r    <= 1'b0;
            ext_valid_r <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_WR_REQ: begin
          if (i_ext_ready || (timer_r == TMO_LAST)) begin
            if (!i_ext_ready) begin
              rdata_r   <= 32'd0;
              timeout_r <= 1'b1;
            end
            ext_addr_r  <= 12'd0;
            ext_wdata_r <= 32'd0;
            ext_wr_r    <= 1'b0;
            ext_rd_r    <= 1'b0;
            ext_valid_r <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_DONE: begin
          timeout_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          ext_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// Randomised self-checking bench for csr_file against an architectural CSR model.
module tb_csr_file;
  localparam int TMO = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rd = 1'b0, i_wr = 1'b0, i_set = 1'b0, i_clr = 1'b0;
  logic [11:0] i_addr = 12'd0;
  logic [31:0] i_wr_data = 32'd0;
  logic        i_retire = 1'b0;
  logic [31:0] o_rd_data;
  logic        o_busy, o_illegal;
  logic [11:0] o_ext_addr;
  logic [31:0] o_ext_wr_data;
  logic        o_ext_wr, o_ext_rd, o_ext_valid;
  logic        i_ext_ready = 1'b0;
  logic [31:0] i_ext_rd_data = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_scr [4];
  logic [63:0] m_cyc, m_ins;

  csr_file dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd(i_rd), .i_wr(i_wr), .i_set(i_set), .i_clr(i_clr),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .i_retire(i_retire), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_illegal(o_illegal), .o_ext_addr(o_ext_addr),
    .o_ext_wr_data(o_ext_wr_data), .o_ext_wr(o_ext_wr), .o_ext_rd(o_ext_rd),
    .o_ext_valid(o_ext_valid), .i_ext_ready(i_ext_ready), .i_ext_rd_data(i_ext_rd_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_internal(input logic [11:0] a);
    return (a >= 12'h7C0 && a <= 12'h7C3) || a == 12'hB00 || a == 12'hB80 || a == 12'hB02 ||
           a == 12'hB82 || a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h7C0: return m_scr[0];
      12'h7C1: return m_scr[1];
      12'h7C2: return m_scr[2];
      12'h7C3: return m_scr[3];
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h7C0: m_scr[0] = v;
      12'h7C1: m_scr[1] = v;
      12'h7C2: m_scr[2] = v;
      12'h7C3: m_scr[3] = v;
      12'hB00: m_cyc[31:0] = v;
      12'hB80: m_cyc[63:32] = v;
      12'hB02: m_ins[31:0] = v;
      12'hB82: m_ins[63:32] = v;
      default: ;
    endcase
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_scr[i] = 32'd0;
    m_cyc = 64'd0;
    m_ins = 64'd0;
  endtask

  task automatic drive(input int op, input logic [11:0] a, input logic [31:0] d);
    i_rd = (op == 0); i_wr = (op == 1); i_set = (op == 2); i_clr = (op == 3);
    i_addr = a; i_wr_data = d;
  endtask

  task automatic tick_model();
    bit r;
    r = i_retire;
    @(posedge i_clk);
    m_cyc = m_cyc + 64'd1;
    if (r) m_ins = m_ins + 64'd1;
    #1;
  endtask

  // One internal (or illegal) access: one cycle, no stall
  task automatic int_op(input int op, input logic [11:0] a, input logic [31:0] d,
                        input bit ret, output logic [31:0] rd);
    logic [31:0] old, nv;
    bit weff, ill, cw, iw;
    drive(op, a, d);
    i_retire = ret;
    old  = m_read(a);
    weff = (op == 1) || ((op >= 2) && d != 32'd0);
    ill  = weff && (a[11:10] == 2'b11);
    nv   = (op == 1) ? d : (op == 2) ? (old | d) : (old & ~d);
    @(negedge i_clk);
    rd = o_rd_data;
    check_val($sformatf("illegal_%03h", a), {31'd0, o_illegal}, {31'd0, ill});
    check_val($sformatf("busy_%03h", a), {31'd0, o_busy}, 32'd0);
    check_val("ext_valid_int", {31'd0, o_ext_valid}, 32'd0);
    if (!ill) check_val($sformatf("rd_%03h", a), o_rd_data, old);
    @(posedge i_clk);
    cw = !ill && weff && (a == 12'hB00 || a == 12'hB80);
    iw = !ill && weff && (a == 12'hB02 || a == 12'hB82);
    if (!cw) m_cyc = m_cyc + 64'd1;
    if (!iw && ret) m_ins = m_ins + 64'd1;
    if (!ill && weff) m_write(a, nv);
    #1;
    drive(0, 12'd0, 32'd0);
    i_rd = 1'b0;
    i_retire = 1'b0;
  endtask

  // One external access; dly/dly2 are ready delays per phase (>= TMO means never)
  task automatic ext_op(input int op, input logic [11:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rv, input int dly2);
    bit tmo;
    logic [31:0] exp_rd, exp_wd;
    drive(op, a, d);
    i_retire = 1'($urandom_range(0, 1));
    i_ext_rd_data = rv;
    i_ext_ready = 1'b0;
    @(negedge i_clk);
    check_val("ext_idle_busy", {31'd0, o_busy}, 32'd1);
    check_val("ext_idle_valid", {31'd0, o_ext_valid}, 32'd0);
    tick_model();
    tmo = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      i_ext_ready = (k == dly);
      i_retire = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      check_val("req_valid", {31'd0, o_ext_valid}, 32'd1);
      check_val("req_busy", {31'd0, o_busy}, 32'd1);
      check_val("req_addr", {20'd0, o_ext_addr}, {20'd0, a});
      check_val("req_rd", {31'd0, o_ext_rd}, {31'd0, op != 1});
      check_val("req_wr", {31'd0, o_ext_wr}, {31'd0, op == 1});
      check_val("req_wdata", o_ext_wr_data, (op == 1) ? d : 32'd0);
      check_val("req_illegal", {31'd0, o_illegal}, 32'd0);
      tick_model();
      if (k == dly) begin
        tmo = 1'b0;
        break;
      end
    end
    i_ext_ready = 1'b0;
    exp_rd = tmo ? 32'd0 : rv;
    if (!tmo && op >= 2 && d != 32'd0) begin
      exp_wd = (op == 2) ? (rv | d) : (rv & ~d);
      tmo = 1'b1;
      for (int k = 0; k < TMO; k++) begin
        i_ext_ready = (k == dly2);
        i_ext_rd_data = $urandom;
        @(negedge i_clk);
        check_val("wr_valid", {31'd0, o_ext_valid}, 32'd1);
        check_val("wr_busy", {31'd0, o_busy}, 32'd1);
        check_val("wr_flags", {30'd0, o_ext_wr, o_ext_rd}, 32'd2);
        check_val("wr_wdata", o_ext_wr_data, exp_wd);
        tick_model();
        if (k == dly2) begin
          tmo = 1'b0;
          break;
        end
      end
      i_ext_ready = 1'b0;
      if (tmo) exp_rd = 32'd0;
    end
    @(negedge i_clk);
    check_val("done_busy", {31'd0, o_busy}, 32'd0);
    check_val("done_valid", {31'd0, o_ext_valid}, 32'd0);
    check_val("done_illegal", {31'd0, o_illegal}, {31'd0, tmo});
    if (op != 1 || tmo) check_val("done_rd", o_rd_data, exp_rd);
    tick_model();
    drive(0, 12'd0, 32'd0);
    i_rd = 1'b0;
    i_retire = 1'b0;
  endtask

  logic [11:0] addrs [16] = '{12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h300, 12'h7C4,
                              12'hC01, 12'h341};

  initial begin
    logic [31:0] rd, d;
    logic [11:0] a;
    int op;
    bit weff;
    m_reset();
    @(posedge i_clk);
    #1;
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_illegal", {31'd0, o_illegal}, 32'd0);
    check_val("rst_ext", {29'd0, o_ext_valid, o_ext_wr, o_ext_rd}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Scratch write / set / clear
    int_op(1, 12'h7C1, 32'hDEADBEEF, 1'b0, rd);
    int_op(2, 12'h7C1, 32'h000000F0, 1'b0, rd);
    check_val("t1_set_old", rd, 32'hDEADBEEF);
    int_op(3, 12'h7C1, 32'h0000000F, 1'b0, rd);
    check_val("t1_clr_old", rd, 32'hDEADBEFF);
    int_op(0, 12'h7C1, 32'd0, 1'b0, rd);
    check_val("t1_final", rd, 32'hDEADBEF0);

    // Counter carry into the high half
    int_op(1, 12'hB80, 32'd0, 1'b0, rd);
    int_op(1, 12'hB00, 32'hFFFFFFFE, 1'b0, rd);
    int_op(0, 12'hC00, 32'd0, 1'b0, rd);
    int_op(0, 12'hC00, 32'd0, 1'b0, rd);
    check_val("t2_lo_max", rd, 32'hFFFFFFFF);
    int_op(0, 12'hC00, 32'd0, 1'b0, rd);
    check_val("t2_lo_wrap", rd, 32'd0);
    int_op(0, 12'hC80, 32'd0, 1'b0, rd);
    check_val("t2_hi_carry", rd, 32'd1);
    int_op(1, 12'hB02, 32'h00001234, 1'b1, rd);
    int_op(0, 12'hC02, 32'd0, 1'b0, rd);
    check_val("t2_instret_wr", rd, 32'h00001234);

    // Read-only space
    int_op(1, 12'hC00, 32'd5, 1'b0, rd);
    int_op(2, 12'hC00, 32'd0, 1'b0, rd);
    check_val("t3_illegal_clear", {31'd0, o_illegal}, 32'd0);

    // External set, timeout
    ext_op(2, 12'h300, 32'h8, 2, 32'h1, 1);
    ext_op(0, 12'h300, 32'd0, TMO + 5, 32'h55, 0);

    // Randomised mix of internal, illegal and external accesses
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 3);
      a = addrs[$urandom_range(0, 15)];
      d = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      weff = (op == 1) || (op >= 2 && d != 32'd0);
      if (m_internal(a) || (weff && a[11:10] == 2'b11))
        int_op(op, a, d, 1'($urandom_range(0, 1)), rd);
      else
        ext_op(op, a, d, $urandom_range(0, TMO + 1), $urandom, $urandom_range(0, TMO + 1));
    end

    // Reset in the middle of a request
    drive(0, 12'h300, 32'd0);
    @(negedge i_clk);
    tick_model();
    @(negedge i_clk);
    check_val("t6_req_valid", {31'd0, o_ext_valid}, 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    check_val("t6_valid_drop", {31'd0, o_ext_valid}, 32'd0);
    check_val("t6_busy_drop", {31'd0, o_busy}, 32'd0);
    drive(0, 12'd0, 32'd0);
    i_rd = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    m_reset();
    int_op(0, 12'hC00, 32'd0, 1'b0, rd);
    check_val("t6_cyc_lo", rd, 32'd0);
    int_op(0, 12'hC80, 32'd0, 1'b0, rd);
    check_val("t6_cyc_hi", rd, 32'd0);
    int_op(0, 12'hC02, 32'd0, 1'b0, rd);
    check_val("t6_instret", rd, 32'd0);
    int_op(0, 12'h7C1, 32'd0, 1'b0, rd);
    check_val("t6_scratch", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
